// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall controller: stage instructions in,
// stall/flush and mult/div sequencing controls out.
interface hazard_stall_unit_if;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned MDOP_W  = 2;

  logic [INSTR_W-1:0] InstrD;
  logic [INSTR_W-1:0] InstrE;
  logic [INSTR_W-1:0] InstrM;
  logic               StallF;
  logic               StallD;
  logic               FlushE;
  logic               MDStart;
  logic [MDOP_W-1:0]  MDOp;
  logic               MDBusy;
  logic               MDDone;

  modport master (
    output InstrD, InstrE, InstrM,
    input  StallF, StallD, FlushE, MDStart, MDOp, MDBusy, MDDone
  );

  modport slave (
    input  InstrD, InstrE, InstrM,
    output StallF, StallD, FlushE, MDStart, MDOp, MDBusy, MDDone
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/sequencing controller for the 5-stage MIPS core: load-use and branch
// operand interlocks plus the busy counter of the multi-cycle mult/div unit.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_unit_if.slave bus
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [FN_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU  = 6'b100011;
  localparam logic [FN_W-1:0] FN_JR    = 6'b001000;
  localparam logic [3:0]      FN_MD    = 4'b0110;
  localparam logic [3:0]      FN_HILO  = 4'b0100;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  logic [OP_W-1:0]    w_op_d, w_op_e, w_op_m;
  logic [FN_W-1:0]    w_fn_d, w_fn_e;
  logic [REG_W-1:0]   w_rs_d, w_rt_d, w_rt_e, w_rd_e, w_rt_m;
  logic [REG_W-1:0]   w_dest_e, w_dest_m;

  logic w_rtype_d, w_md_d, w_hilo_d, w_calr_d, w_ori_d, w_lw_d, w_sw_d, w_beq_d, w_jr_d;
  logic w_rd_rs_d, w_rd_rt_d;
  logic w_rtype_e, w_md_e, w_lw_e, w_calr_e, w_cali_e;
  logic w_lw_m;
  logic w_hit_e, w_hit_m;
  logic w_load_use, w_branch, w_md_stall, w_stall;
  logic w_md_start, w_busy;
  logic w_unused;

  // Instruction fields per stage
  assign w_op_d = bus.InstrD[31:26];
  assign w_rs_d = bus.InstrD[25:21];
  assign w_rt_d = bus.InstrD[20:16];
  assign w_fn_d = bus.InstrD[5:0];
  assign w_op_e = bus.InstrE[31:26];
  assign w_rt_e = bus.InstrE[20:16];
  assign w_rd_e = bus.InstrE[15:11];
  assign w_fn_e = bus.InstrE[5:0];
  assign w_op_m = bus.InstrM[31:26];
  assign w_rt_m = bus.InstrM[20:16];

  assign w_unused = ^{bus.InstrD[15:6], bus.InstrE[25:21], bus.InstrE[10:6],
                      bus.InstrM[25:21], bus.InstrM[15:0]};

  // D-stage decode: class and which source registers it reads
  assign w_rtype_d = (w_op_d == OP_RTYPE);
  assign w_md_d    = w_rtype_d && (w_fn_d[5:2] == FN_MD);
  assign w_hilo_d  = w_md_d || (w_rtype_d && (w_fn_d[5:2] == FN_HILO));
  assign w_calr_d  = w_rtype_d && ((w_fn_d == FN_ADDU) || (w_fn_d == FN_SUBU));
  assign w_ori_d   = (w_op_d == OP_ORI);
  assign w_lw_d    = (w_op_d == OP_LW);
  assign w_sw_d    = (w_op_d == OP_SW);
  assign w_beq_d   = (w_op_d == OP_BEQ);
  assign w_jr_d    = w_rtype_d && (w_fn_d == FN_JR);
  assign w_rd_rs_d = w_calr_d || w_ori_d || w_lw_d || w_sw_d || w_beq_d || w_jr_d || w_md_d;
  assign w_rd_rt_d = w_calr_d || w_sw_d || w_beq_d || w_md_d;

  // E/M-stage decode: destination register (0 means no write)
  assign w_rtype_e = (w_op_e == OP_RTYPE);
  assign w_md_e    = w_rtype_e && (w_fn_e[5:2] == FN_MD);
  assign w_lw_e    = (w_op_e == OP_LW);
  assign w_calr_e  = w_rtype_e && ((w_fn_e == FN_ADDU) || (w_fn_e == FN_SUBU));
  assign w_cali_e  = (w_op_e == OP_ORI) || (w_op_e == OP_LUI);
  assign w_dest_e  = w_calr_e ? w_rd_e : ((w_cali_e || w_lw_e) ? w_rt_e : '0);
  assign w_lw_m    = (w_op_m == OP_LW);
  assign w_dest_m  = w_lw_m ? w_rt_m : '0;

  assign w_hit_e = (w_dest_e != '0) &&
                   ((w_rd_rs_d && (w_rs_d == w_dest_e)) || (w_rd_rt_d && (w_rt_d == w_dest_e)));
  assign w_hit_m = (w_dest_m != '0) &&
                   ((w_rd_rs_d && (w_rs_d == w_dest_m)) || (w_rd_rt_d && (w_rt_d == w_dest_m)));

  // Branches resolve in D, so even ALU results in E are too late for them
  assign w_load_use = w_lw_e && w_hit_e;
  assign w_branch   = (w_beq_d || w_jr_d) &&
                      (((w_calr_e || w_cali_e || w_lw_e) && w_hit_e) || w_hit_m);
  assign w_busy     = (r_state == S_BUSY);
  assign w_md_start = w_md_e && !reset;
  assign w_md_stall = w_hilo_d && (w_md_start || w_busy);
  assign w_stall    = w_load_use || w_branch || w_md_stall;

  // Mult/div busy sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: load on start, count down while busy, never below zero
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_md_start) begin
      w_cnt_next   = bus.InstrE[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      w_state_next = S_BUSY;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_next = '0;
        end
        S_BUSY: begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.StallF  = w_stall;
  assign bus.StallD  = w_stall;
  assign bus.FlushE  = w_stall;
  assign bus.MDStart = w_md_start;
  assign bus.MDOp    = bus.InstrE[1:0];
  assign bus.MDBusy  = w_busy;
  assign bus.MDDone  = w_busy && (r_cnt == CNT_W'(1));

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: per-cycle vectors push expected outputs
// into a scoreboard queue that a negedge monitor drains and compares.
module tb_hazard_stall_unit;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] LW_1      = 32'h8C01_0000; // lw   $1,0($0)
  localparam logic [31:0] LW_0      = 32'h8C00_0000; // lw   $0,0($0)
  localparam logic [31:0] LW_4      = 32'h8C04_0000; // lw   $4,0($0)
  localparam logic [31:0] ADDU_213  = 32'h0023_1021; // addu $2,$1,$3
  localparam logic [31:0] ADDU_203  = 32'h0003_1021; // addu $2,$0,$3
  localparam logic [31:0] ADDU_913  = 32'h0023_4821; // addu $9,$1,$3
  localparam logic [31:0] ADDU_293  = 32'h0123_1021; // addu $2,$9,$3
  localparam logic [31:0] LUI_2_RS1 = 32'h3C22_0000; // lui  $2 (rs field = 1)
  localparam logic [31:0] BEQ_45    = 32'h1085_0000; // beq  $4,$5
  localparam logic [31:0] BEQ_40    = 32'h1080_0000; // beq  $4,$0
  localparam logic [31:0] ORI_5     = 32'h3405_0010; // ori  $5,$0,0x10
  localparam logic [31:0] JR_9      = 32'h0120_0008; // jr   $9
  localparam logic [31:0] MULT_67   = 32'h00C7_0018;
  localparam logic [31:0] MULTU_67  = 32'h00C7_0019;
  localparam logic [31:0] DIV_67    = 32'h00C7_001A;
  localparam logic [31:0] DIVU_67   = 32'h00C7_001B;
  localparam logic [31:0] MFLO_8    = 32'h0000_4012;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  hazard_stall_unit_if bus ();

  hazard_stall_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input string name, input logic rst,
                      input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                      input logic stall, input logic start, input logic [1:0] op,
                      input logic busy, input logic done);
    exp_t x;
    @(posedge clk);
    #1;
    reset      = rst;
    bus.InstrD = d;
    bus.InstrE = e;
    bus.InstrM = m;
    x.name = name;
    x.exp  = {stall, stall, stall, start, op, busy, done};
    sb_q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle, compare against queue head
  initial begin
    exp_t       x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x   = sb_q.pop_front();
        act = {bus.StallF, bus.StallD, bus.FlushE, bus.MDStart, bus.MDOp, bus.MDBusy, bus.MDDone};
        checks++;
        if (act !== x.exp) begin
          errors++;
          $display("FAIL %s: got {sF,sD,fE,start,op,busy,done}=%b expected %b", x.name, act, x.exp);
        end
        checks++;
        if (bus.MDStart === 1'b1 && bus.MDBusy === 1'b1) begin
          errors++;
          $display("FAIL %s start_while_busy: MDStart=%b MDBusy=%b expected not both 1",
                   x.name, bus.MDStart, bus.MDBusy);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.InstrD = NOP;
    bus.InstrE = NOP;
    bus.InstrM = NOP;

    step("reset_cycle",   1'b1, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step("post_reset",    1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    step("load_use",      1'b0, ADDU_213, LW_1, NOP, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("load_use_nopE", 1'b0, ADDU_213, NOP,  LW_1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step("load_use_r0",   1'b0, ADDU_203, LW_0, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step("lui_no_rs",     1'b0, LUI_2_RS1, LW_1, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    step("beq_ori_in_E",  1'b0, BEQ_45, ORI_5, NOP, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("beq_ori_in_M",  1'b0, BEQ_45, NOP, ORI_5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step("beq_lw_in_M",   1'b0, BEQ_40, NOP, LW_4,  1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("jr_addu_in_E",  1'b0, JR_9, ADDU_913, NOP, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    step("alu_fwd_ok",    1'b0, ADDU_293, ADDU_913, NOP, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);

    // mult in E at t with mflo waiting in D
    step("mult_start",    1'b0, MFLO_8, MULT_67, NOP, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("mult_busy%0d", i), 1'b0, MFLO_8, NOP, NOP, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    step("mult_done",     1'b0, MFLO_8, NOP, NOP, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step("mflo_issues",   1'b0, MFLO_8, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // div: ten busy cycles, unrelated instruction in D never stalls
    step("div_start",     1'b0, NOP, DIV_67, NOP, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      step($sformatf("div_busy%0d", i), 1'b0, ADDU_213, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step("div_done",      1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    step("div_idle",      1'b0, MFLO_8, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // divu interrupted by reset at t+3
    step("divu_start",    1'b0, NOP, DIVU_67, NOP, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    step("divu_busy1",    1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step("divu_busy2",    1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step("divu_rst",      1'b1, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++)
      step($sformatf("divu_after_rst%0d", i), 1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // md in E during reset must not start the unit
    step("multu_in_rst",  1'b1, MFLO_8, MULTU_67, NOP, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    step("multu_no_busy", 1'b0, MFLO_8, NOP, NOP, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
